// File: rtl/tdm_mux_arbiter.sv
// Two-channel TDM arbiter feeding a registered 2:1 mux with a one-entry output buffer.
// Optional per-channel grant counters are enabled by defining TDM_MUX_CNT_EN.
module tdm_mux_arbiter #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S0,
  output logic [WIDTH-1:0] Y,
  output logic             VALID,
  input  logic             READY
`ifdef TDM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [0:0]       state_p1;
  logic [WIDTH-1:0] y_p1;
  logic             s0_p1;
  logic             last_p1;
  logic             load_slot;
  logic             gnt0;
  logic             gnt1;

  // Grant decision: data inputs never feed the grant path.
  always_comb begin
    load_slot = (state_p1 == ST_EMPTY) || READY;
    gnt0      = rst_n && load_slot && REQ0 && (!REQ1 || last_p1);
    gnt1      = rst_n && load_slot && REQ1 && (!REQ0 || !last_p1);
  end

  // Stage p1: output buffer and last-served pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_EMPTY;
      y_p1     <= '0;
      s0_p1    <= 1'b0;
      last_p1  <= 1'b1;
    end else if (gnt0 || gnt1) begin
      state_p1 <= ST_FULL;
      y_p1     <= gnt1 ? D1 : D0;
      s0_p1    <= gnt1;
      last_p1  <= gnt1;
    end else if (state_p1 == ST_FULL && READY) begin
      state_p1 <= ST_EMPTY;
    end
  end

  assign GNT0  = gnt0;
  assign GNT1  = gnt1;
  assign S0    = s0_p1;
  assign Y     = y_p1;
  assign VALID = (state_p1 == ST_FULL);

`ifdef TDM_MUX_CNT_EN
  logic [CNT_W-1:0] cnt0_p1;
  logic [CNT_W-1:0] cnt1_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_p1 <= '0;
      cnt1_p1 <= '0;
    end else begin
      if (gnt0) cnt0_p1 <= sat_inc(cnt0_p1);
      if (gnt1) cnt1_p1 <= sat_inc(cnt1_p1);
    end
  end

  assign CNT0 = cnt0_p1;
  assign CNT1 = cnt1_p1;
`endif

endmodule

// File: tb/tb_tdm_mux_arbiter.sv
// Directed bench for tdm_mux_arbiter; counter checks are active when TDM_MUX_CNT_EN is defined.
module tb_tdm_mux_arbiter;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             REQ0, REQ1, READY;
  logic [WIDTH-1:0] D0, D1;
  logic             GNT0, GNT1, S0, VALID;
  logic [WIDTH-1:0] Y;
`ifdef TDM_MUX_CNT_EN
  logic [CNT_W-1:0] CNT0, CNT1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ0(REQ0), .D0(D0), .REQ1(REQ1), .D1(D1),
    .GNT0(GNT0), .GNT1(GNT1), .S0(S0), .Y(Y),
    .VALID(VALID), .READY(READY)
`ifdef TDM_MUX_CNT_EN
    , .CNT0(CNT0), .CNT1(CNT1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; READY = 1'b1; D0 = '0; D1 = '0;
    #1;
    chk("rst_gnt0", GNT0, 0);
    chk("rst_gnt1", GNT1, 0);
    tick();
    chk("rst_valid", VALID, 0);
    chk("rst_y", Y, 0);
    chk("rst_s0", S0, 0);

    // Single request on channel 0
    rst_n = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; READY = 1'b0;
    tick();
    REQ0 = 1'b1; D0 = 4'h1; READY = 1'b1;
    #1;
    chk("single_gnt0", GNT0, 1);
    chk("single_gnt1", GNT1, 0);
    tick();
    chk("single_valid", VALID, 1);
    chk("single_y", Y, 4'h1);
    chk("single_s0", S0, 0);

    // Drain with no request, then READY toggling while empty
    REQ0 = 1'b0;
    #1;
    chk("drain_gnt0", GNT0, 0);
    tick();
    chk("drain_valid", VALID, 0);
    chk("drain_y_hold", Y, 4'h1);
    READY = 1'b0;
    tick();
    chk("empty_rdy0_valid", VALID, 0);
    READY = 1'b1;
    tick();
    chk("empty_rdy1_valid", VALID, 0);
    chk("empty_y_hold", Y, 4'h1);

    // Alternation with both requesting after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'h0; D1 = 4'h1; READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_gnt0", GNT0, (i % 2 == 0));
      chk("alt_gnt1", GNT1, (i % 2 == 1));
      tick();
      chk("alt_y", Y, i % 2);
      chk("alt_s0", S0, i % 2);
      chk("alt_valid", VALID, 1);
    end

    // Back-pressure: fill from channel 1, hold with READY=0
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk("bp_empty", VALID, 0);
    REQ1 = 1'b1; D1 = 4'h1;
    #1;
    chk("bp_fill_gnt1", GNT1, 1);
    tick();
    chk("bp_fill_y", Y, 4'h1);
    chk("bp_fill_s0", S0, 1);
    REQ1 = 1'b0; REQ0 = 1'b1; D0 = 4'h6; READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_gnt0", GNT0, 0);
      tick();
      chk("bp_hold_y", Y, 4'h1);
      chk("bp_hold_s0", S0, 1);
      chk("bp_hold_valid", VALID, 1);
    end
    READY = 1'b1;
    #1;
    chk("bp_rel_gnt0", GNT0, 1);
    tick();
    chk("bp_rel_s0", S0, 0);
    chk("bp_rel_y", Y, 4'h6);
    chk("bp_rel_valid", VALID, 1);

    // Reset while full with a pending channel 1 request
    REQ0 = 1'b0; REQ1 = 1'b1; D1 = 4'h9; READY = 1'b1; rst_n = 1'b0;
    #1;
    chk("midrst_gnt1", GNT1, 0);
    tick();
    chk("midrst_valid", VALID, 0);
    chk("midrst_y", Y, 0);
    chk("midrst_s0", S0, 0);
    rst_n = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'hA;
    #1;
    chk("postrst_gnt0", GNT0, 1);
    chk("postrst_gnt1", GNT1, 0);
    tick();
    chk("postrst_s0", S0, 0);
    chk("postrst_y", Y, 4'hA);

    // Four more channel-0 grants: five since reset
    REQ1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("run0_gnt0", GNT0, 1);
      tick();
    end
`ifdef TDM_MUX_CNT_EN
    chk("cnt0_sat", CNT0, 3);
    chk("cnt1_zero", CNT1, 0);
`endif
    chk("run0_valid", VALID, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_mux_arbiter.md
TDM_MUX_ARBITER -- requirements
Module: tdm_mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 1, data width of each channel and of Y.
REQ-002 Parameter: CNT_W, default 8, width of grant counters (used only with TDM_MUX_CNT_EN).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: REQ0  input  1  channel 0 has a sample on D0.
REQ-006 Port: D0  input  WIDTH  channel 0 data; stable while REQ0=1 until GNT0.
REQ-007 Port: REQ1  input  1  channel 1 has a sample on D1.
REQ-008 Port: D1  input  WIDTH  channel 1 data; stable while REQ1=1 until GNT1.
REQ-009 Port: GNT0  output  1  one-cycle acceptance of channel 0 sample (combinational).
REQ-010 Port: GNT1  output  1  one-cycle acceptance of channel 1 sample (combinational).
REQ-011 Port: S0  output  1  registered select for the downstream 2:1 mux; 0=channel 0, 1=channel 1.
REQ-012 Port: Y  output  WIDTH  registered multiplexed sample.
REQ-013 Port: VALID  output  1  Y holds an unconsumed sample.
REQ-014 Port: READY  input  1  consumer accepts Y when VALID=1 and READY=1.

Function
REQ-015 FSM SHALL have two states: EMPTY (VALID=0) and FULL (VALID=1).
REQ-016 Load slot SHALL exist in a cycle when state=EMPTY, or state=FULL with READY=1.
REQ-017 In a load slot with REQ0|REQ1=1, exactly one grant SHALL assert; with no load slot or no request, GNT0=GNT1=0.
REQ-018 Only REQ0 -> GNT0; only REQ1 -> GNT1; both -> grant the channel not equal to LAST (last-served pointer).
REQ-019 On grant of channel k: next cycle Y=Dk, S0=k, LAST=k, state=FULL; latency REQ-to-VALID = 1 cycle.
REQ-020 Load slot in FULL with READY=1 and no request SHALL go to EMPTY; Y, S0, LAST hold previous values.
REQ-021 FULL with READY=0 SHALL hold Y, S0, VALID, LAST unchanged; no grant.
REQ-022 Simultaneous drain and load (FULL, READY=1, request present) SHALL replace Y in the same edge, VALID staying 1; sustains one sample per cycle.
REQ-023 Both channels continuously requesting with READY=1 SHALL alternate grants every cycle: 0,1,0,1... after reset.
REQ-024 READY SHALL be ignored while VALID=0.
REQ-025 GNTx SHALL not depend combinationally on Dx; it depends only on REQx, state, READY, LAST.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=EMPTY, VALID=0, Y=0, S0=0, LAST=1 (so channel 0 wins first tie).
REQ-027 While rst_n=0, GNT0=GNT1=0 regardless of requests.
REQ-028 Reset mid-operation SHALL discard any held sample without a handshake; no grant issued in the reset cycle.

Configuration
REQ-029 Macro TDM_MUX_CNT_EN defined: outputs CNT0, CNT1 (CNT_W each) SHALL count GNT0/GNT1 pulses, saturating at all-ones, cleared by reset.
REQ-030 Macro TDM_MUX_CNT_EN undefined: CNT0/CNT1 ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset then REQ0=1,D0=1,READY=1 one cycle -> GNT0=1 that cycle; next cycle VALID=1,Y=1,S0=0.
REQ-032 REQ0=REQ1=1, D0=0, D1=1, READY=1 for 4 cycles after reset -> grants 0,1,0,1; Y sequence 0,1,0,1; S0 sequence 0,1,0,1.
REQ-033 Fill with D1=1, hold READY=0 for 3 cycles with REQ0=1 -> Y=1,S0=1 held, GNT0=0 throughout; READY=1 -> GNT0=1, next cycle S0=0.
REQ-034 FULL, READY=1, no requests -> next cycle VALID=0; READY toggling while EMPTY -> no state change.
REQ-035 rst_n=0 while FULL with REQ1=1 -> no GNT1, next cycle VALID=0,Y=0,S0=0; first tie after release granted to channel 0.
REQ-036 With TDM_MUX_CNT_EN, CNT_W=2: 5 consecutive GNT0 -> CNT0=3 (saturated), CNT1=0.
